// File: rtl/sample_rate_timer.sv
// Sample-rate tick generator: turns a requested audio rate into a clk-cycle period
// with a serial divider, and raises a level-held sample request once per period.
module sample_rate_timer #(
   parameter logic [31:0] SYS_CLK_FREQ     = 32'd50_000_000,
   parameter logic [31:0] INITIAL_CLK_FREQ = 32'd22_000,
   parameter logic [31:0] MIN_FREQ         = 32'd1_000,
   parameter logic [31:0] MAX_FREQ         = 32'd48_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] freq_in,
   input  logic        enable,
   input  logic        sample_ack,
   output logic        sample_req,
   output logic [31:0] divisor,
   output logic [31:0] active_freq,
   output logic        busy,
   output logic [15:0] overrun_count
);

   localparam logic [31:0] RESET_DIVISOR = SYS_CLK_FREQ / INITIAL_CLK_FREQ;
   localparam logic [0:0]  ST_RUN        = 1'b0;
   localparam logic [0:0]  ST_DIVIDE     = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [31:0] pending_q, pending_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quot_q, quot_d;
   logic [5:0]  iter_q, iter_d;
   logic [31:0] divisor_q, divisor_d;
   logic [31:0] active_q, active_d;
   logic        busy_q, busy_d;
   logic [31:0] cnt_q, cnt_d;
   logic        req_q, req_d;
   logic [15:0] ovr_q, ovr_d;

   logic [31:0] clamp_s;
   logic [32:0] shift_s;
   logic [31:0] diff_s;
   logic        tick_s;
   logic        load_s;

   // Requested rate limited to the supported window (unsigned compare).
   always_comb begin
      clamp_s = freq_in;
      if (freq_in < MIN_FREQ) begin
         clamp_s = MIN_FREQ;
      end else if (freq_in > MAX_FREQ) begin
         clamp_s = MAX_FREQ;
      end else begin
         clamp_s = freq_in;
      end
   end

   // Restoring step: the dividend streams out of the quotient register's MSB.
   assign shift_s = {rem_q, quot_q[31]};
   assign diff_s  = shift_s[31:0] - pending_q;
   assign tick_s  = enable && (cnt_q == (divisor_q - 32'd1));

   // Rate-change FSM and the 32-step divider; load_s marks the result edge.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      rem_d     = rem_q;
      quot_d    = quot_q;
      iter_d    = iter_q;
      divisor_d = divisor_q;
      active_d  = active_q;
      busy_d    = busy_q;
      load_s    = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (clamp_s != active_q) begin
               pending_d = clamp_s;
               rem_d     = 32'd0;
               quot_d    = SYS_CLK_FREQ;
               iter_d    = 6'd0;
               busy_d    = 1'b1;
               state_d   = ST_DIVIDE;
            end else begin
               busy_d    = 1'b0;
            end
         end
         ST_DIVIDE: begin
            if (iter_q == 6'd32) begin
               divisor_d = quot_q;
               active_d  = pending_q;
               busy_d    = 1'b0;
               load_s    = 1'b1;
               state_d   = ST_RUN;
            end else begin
               if (shift_s >= {1'b0, pending_q}) begin
                  rem_d  = diff_s;
                  quot_d = {quot_q[30:0], 1'b1};
               end else begin
                  rem_d  = shift_s[31:0];
                  quot_d = {quot_q[30:0], 1'b0};
               end
               iter_d = iter_q + 6'd1;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_RUN;
         end
      endcase
   end

   // Period counter keeps using the old divisor until a new one is loaded.
   always_comb begin
      cnt_d = cnt_q;
      if (load_s || !enable || tick_s) begin
         cnt_d = 32'd0;
      end else begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   // Request handshake; a tick over an unacknowledged request counts as an overrun.
   always_comb begin
      req_d = req_q;
      ovr_d = ovr_q;
      if (tick_s) begin
         req_d = 1'b1;
         if (req_q && !sample_ack && (ovr_q != 16'hFFFF)) begin
            ovr_d = ovr_q + 16'd1;
         end else begin
            ovr_d = ovr_q;
         end
      end else if (req_q && sample_ack) begin
         req_d = 1'b0;
      end else begin
         req_d = req_q;
      end
   end

   // State registers; reset discards any division in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_RUN;
         pending_q <= INITIAL_CLK_FREQ;
         rem_q     <= 32'd0;
         quot_q    <= 32'd0;
         iter_q    <= 6'd0;
         divisor_q <= RESET_DIVISOR;
         active_q  <= INITIAL_CLK_FREQ;
         busy_q    <= 1'b0;
         cnt_q     <= 32'd0;
         req_q     <= 1'b0;
         ovr_q     <= 16'd0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         rem_q     <= rem_d;
         quot_q    <= quot_d;
         iter_q    <= iter_d;
         divisor_q <= divisor_d;
         active_q  <= active_d;
         busy_q    <= busy_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         ovr_q     <= ovr_d;
      end
   end

   assign sample_req    = req_q;
   assign divisor       = divisor_q;
   assign active_freq   = active_q;
   assign busy          = busy_q;
   assign overrun_count = ovr_q;

endmodule

// File: tb/tb_sample_rate_timer.sv
// Scoreboard bench for sample_rate_timer: the driver queues expected request edges and
// divide results from a rate/period model; a negedge monitor pops and compares them.
module tb_sample_rate_timer;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] freq_in;
   logic        enable;
   logic        sample_ack;
   logic        sample_req;
   logic [31:0] divisor;
   logic [31:0] active_freq;
   logic        busy;
   logic [15:0] overrun_count;

   sample_rate_timer dut (
      .clk           (clk),
      .reset         (reset),
      .freq_in       (freq_in),
      .enable        (enable),
      .sample_ack    (sample_ack),
      .sample_req    (sample_req),
      .divisor       (divisor),
      .active_freq   (active_freq),
      .busy          (busy),
      .overrun_count (overrun_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] freq;
      logic [31:0] div;
   } div_exp_t;

   int unsigned cyc = 0;
   int          chk_cnt = 0;
   int          pass_cnt = 0;
   int unsigned q_rise[$];
   div_exp_t    q_div[$];
   logic        auto_ack = 1'b1;
   logic        manual_ack = 1'b0;
   int unsigned last_rise = 0;
   logic [31:0] cur_div = 32'd2272;
   logic        prev_req = 1'b0;
   logic        prev_busy = 1'b0;
   int unsigned busy_len = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [31:0] clampf(input logic [31:0] f);
      if (f < 32'd1000) return 32'd1000;
      if (f > 32'd48000) return 32'd48000;
      return f;
   endfunction

   // Number of rising edges seen so far; at a negedge it names the edge just passed.
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      sample_ack = 1'b0;
      forever begin
         @(negedge clk);
         sample_ack = auto_ack ? sample_req : manual_ack;
      end
   end

   // Monitor: request rising edges and end-of-divide events are popped from the scoreboard.
   initial forever begin
      @(negedge clk);
      if (reset) begin
         busy_len = 0;
      end else begin
         if (busy) busy_len++;
         if (sample_req && !prev_req) begin
            if (q_rise.size() == 0) begin
               chk_cnt++;
               $display("FAIL unexpected_rise: sample_req rose at edge %0d, none expected", cyc);
            end else begin
               check32("rise_edge", cyc, q_rise.pop_front());
            end
            last_rise = cyc;
         end
         if (!busy && prev_busy) begin
            if (q_div.size() == 0) begin
               chk_cnt++;
               $display("FAIL unexpected_divide: busy fell at edge %0d, none expected", cyc);
            end else begin
               div_exp_t e;
               e = q_div.pop_front();
               check32("active_freq", active_freq, e.freq);
               check32("divisor", divisor, e.div);
               check32("busy_cycles", busy_len, 32'd33);
            end
            busy_len = 0;
         end
      end
      prev_req  = sample_req;
      prev_busy = busy;
   end

   task automatic drain(input int budget, input string name);
      int n = 0;
      while ((q_rise.size() != 0 || q_div.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (q_rise.size() != 0 || q_div.size() != 0) begin
         chk_cnt++;
         $display("FAIL %s_timeout: %0d request edges and %0d divides still pending, required 0",
                  name, q_rise.size(), q_div.size());
         q_rise.delete();
         q_div.delete();
      end
   endtask

   // New rate applied at a negedge: the divide result lands 34 edges later and the
   // period restarts from that edge.
   task automatic change_freq(input logic [31:0] f, input int nrises);
      int unsigned c;
      div_exp_t    e;
      @(negedge clk);
      freq_in = f;
      c = cyc;
      e.freq = clampf(f);
      e.div  = 32'd50_000_000 / e.freq;
      q_div.push_back(e);
      for (int n = 1; n <= nrises; n++) q_rise.push_back(c + 34 + n * e.div);
      cur_div = e.div;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rf;
      int unsigned t;
      int unsigned e0;

      reset   = 1'b1;
      enable  = 1'b0;
      freq_in = 32'd22000;
      repeat (3) @(negedge clk);
      check32("rst_divisor", divisor, 32'd2272);
      check32("rst_active_freq", active_freq, 32'd22000);
      check32("rst_sample_req", {31'd0, sample_req}, 32'd0);
      check32("rst_busy", {31'd0, busy}, 32'd0);
      check32("rst_overrun", {16'd0, overrun_count}, 32'd0);

      // Enable low: no requests at all.
      reset = 1'b0;
      repeat (3000) @(negedge clk);
      check32("disabled_no_req", {31'd0, sample_req}, 32'd0);

      // Nominal rate with prompt acknowledge.
      enable = 1'b1;
      e0 = cyc;
      for (int n = 1; n <= 3; n++) q_rise.push_back(e0 + n * 2272);
      drain(3 * 2272 + 50, "nominal");
      check32("nominal_overrun", {16'd0, overrun_count}, 32'd0);

      repeat ($urandom_range(20, 2)) @(negedge clk);
      change_freq(32'd22100, 1);
      drain(2400, "rate_22100");

      repeat ($urandom_range(20, 2)) @(negedge clk);
      change_freq(32'd0, 0);
      drain(60, "clamp_low");

      repeat ($urandom_range(20, 2)) @(negedge clk);
      change_freq(32'hFFFF_FF9C, 2);
      drain(2200, "clamp_high");

      repeat ($urandom_range(20, 2)) @(negedge clk);
      rf = $urandom_range(47999, 20000);
      change_freq(rf, 1);
      drain(2600, "rate_random");
      check32("rates_overrun", {16'd0, overrun_count}, 32'd0);

      // Overrun: three ticks without an acknowledge.
      repeat (2) @(negedge clk);
      auto_ack = 1'b0;
      t = last_rise;
      q_rise.push_back(t + cur_div);
      while (cyc < t + 3 * cur_div + 2) @(negedge clk);
      drain(5, "overrun_rise");
      check32("overrun_count", {16'd0, overrun_count}, 32'd2);
      check32("overrun_req_held", {31'd0, sample_req}, 32'd1);
      manual_ack = 1'b1;
      repeat (2) @(negedge clk);
      check32("overrun_ack_clears", {31'd0, sample_req}, 32'd0);
      check32("overrun_after_ack", {16'd0, overrun_count}, 32'd2);
      manual_ack = 1'b0;
      auto_ack   = 1'b1;

      // Reset in the middle of a division.
      @(negedge clk);
      freq_in = 32'd40000;
      repeat (10) @(negedge clk);
      check32("busy_mid_divide", {31'd0, busy}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check32("midrst_divisor", divisor, 32'd2272);
      check32("midrst_active_freq", active_freq, 32'd22000);
      check32("midrst_busy", {31'd0, busy}, 32'd0);
      check32("midrst_sample_req", {31'd0, sample_req}, 32'd0);
      check32("midrst_overrun", {16'd0, overrun_count}, 32'd0);
      @(negedge clk);
      freq_in = 32'd22000;
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      check32("postrst_divisor", divisor, 32'd2272);
      check32("postrst_busy", {31'd0, busy}, 32'd0);
      check32("postrst_active_freq", active_freq, 32'd22000);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
